// File: rtl/surf6_fwu_pkg.sv
// surf6_fwu_pkg: shared types and constants for the firmware-update buffer writer.
//   fwu_state_e        - writer state machine encoding
//   FWU_WORD_W/BYTE_W  - buffer word and command byte widths
//   HALF_A/HALF_B      - half-buffer select values
//   half_mask()        - one-hot pulse vector for a half
package surf6_fwu_pkg;
  localparam int FWU_WORD_W = 32;
  localparam int FWU_BYTE_W = 8;
  localparam logic HALF_A = 1'b0;
  localparam logic HALF_B = 1'b1;
  typedef enum logic [2:0] {ST_IDLE, ST_FILL, ST_FULL, ST_FLUSH, ST_MARK} fwu_state_e;
  function automatic logic [1:0] half_mask(input logic h);
    return (h == HALF_B) ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/surf6_fwu_byte_packer.sv
// surf6_fwu_byte_packer: little-endian byte-to-word assembly.
//   ifclk_i/rst_n_i - clock, async active-low reset
//   clr             - synchronous discard of any held bytes
//   push/dat        - accepted byte
//   byte_idx        - bytes held in the current word
//   word/word_done  - completed word, valid while the 4th byte is pushed
//   part            - held bytes with unfilled upper bytes zero
module surf6_fwu_byte_packer
  import surf6_fwu_pkg::*;
(
  input  logic                  ifclk_i,
  input  logic                  rst_n_i,
  input  logic                  clr,
  input  logic                  push,
  input  logic [FWU_BYTE_W-1:0] dat,
  output logic [1:0]            byte_idx,
  output logic [FWU_WORD_W-1:0] word,
  output logic [FWU_WORD_W-1:0] part,
  output logic                  word_done
);
  localparam int ACC_W = FWU_WORD_W - FWU_BYTE_W;
  logic [ACC_W-1:0] acc;
  assign word_done = push && byte_idx == 2'd3;
  assign word = {dat, acc};
  assign part = {{FWU_BYTE_W{1'b0}}, acc};
  always_ff @(posedge ifclk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      acc      <= '0;
      byte_idx <= '0;
    end else if (clr) begin
      acc      <= '0;
      byte_idx <= '0;
    end else if (push) begin
      acc      <= word_done ? '0 : acc | (ACC_W'(dat) << {byte_idx, 3'b000});
      byte_idx <= byte_idx + 2'd1;
    end
endmodule

// File: rtl/surf6_fwu_buffer_writer.sv
// surf6_fwu_buffer_writer: packs firmware bytes into 32-bit words written to a double-buffered event buffer.
//   ifclk_i/rst_n_i          - clock, async active-low reset
//   fwu_dat_i/valid_i/ready_o - byte stream in
//   fwu_mark_i               - close and mark the current half
//   buf_addr_o/dat_o/we_o    - buffer write port, address MSB selects the half
//   fw_wr_o/fw_mark_o        - per-half first-write and marked pulses
//   cur_half_o               - half being filled
module surf6_fwu_buffer_writer
  import surf6_fwu_pkg::*;
#(
  parameter int HALF_WORDS = 1024,
  parameter int ADDR_W     = $clog2(HALF_WORDS) + 1
) (
  input  logic                  ifclk_i,
  input  logic                  rst_n_i,
  input  logic [FWU_BYTE_W-1:0] fwu_dat_i,
  input  logic                  fwu_valid_i,
  output logic                  fwu_ready_o,
  input  logic                  fwu_mark_i,
  output logic [ADDR_W-1:0]     buf_addr_o,
  output logic [FWU_WORD_W-1:0] buf_dat_o,
  output logic                  buf_we_o,
  output logic [1:0]            fw_wr_o,
  output logic [1:0]            fw_mark_o,
  output logic                  cur_half_o
);
  fwu_state_e state, state_nx;
  logic ready_en, cur_half, accept, word_done, wr;
  logic [ADDR_W-1:0] widx;
  logic [1:0] byte_idx, idx_nx;
  logic [FWU_WORD_W-1:0] word, part;
  // ready_en keeps the byte port closed until the first edge after reset release
  assign fwu_ready_o = ready_en && (state == ST_IDLE || state == ST_FILL);
  assign accept = fwu_valid_i && fwu_ready_o;
  // byte count after this cycle's transfer, so a same-cycle byte lands before the mark decision
  assign idx_nx = byte_idx + {1'b0, accept};
  assign wr = word_done || state == ST_FLUSH;
  assign cur_half_o = cur_half;
  assign fw_mark_o = (state == ST_MARK) ? half_mask(cur_half) : 2'b00;
  surf6_fwu_byte_packer u_packer (
    .ifclk_i  (ifclk_i),
    .rst_n_i  (rst_n_i),
    .clr      (state == ST_MARK),
    .push     (accept),
    .dat      (fwu_dat_i),
    .byte_idx (byte_idx),
    .word     (word),
    .part     (part),
    .word_done(word_done)
  );
  always_ff @(posedge ifclk_i or negedge rst_n_i)
    if (!rst_n_i) state <= ST_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_FILL:
        if (state == ST_IDLE && !accept) state_nx = ST_IDLE;
        else if (fwu_mark_i) state_nx = (idx_nx != 2'd0) ? ST_FLUSH : ST_MARK;
        else if (word_done && widx == ADDR_W'(HALF_WORDS - 1)) state_nx = ST_FULL;
        else state_nx = ST_FILL;
      ST_FULL:  if (fwu_mark_i) state_nx = (byte_idx != 2'd0) ? ST_FLUSH : ST_MARK;
      ST_FLUSH: state_nx = ST_MARK;
      ST_MARK:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end
  // word index only moves on writes and clears on MARK, so index 0 is exactly the first write of a half
  always_ff @(posedge ifclk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      ready_en   <= 1'b0;
      cur_half   <= HALF_A;
      widx       <= '0;
      buf_we_o   <= 1'b0;
      buf_addr_o <= '0;
      buf_dat_o  <= '0;
      fw_wr_o    <= 2'b00;
    end else begin
      ready_en <= 1'b1;
      buf_we_o <= wr;
      fw_wr_o  <= (wr && widx == '0) ? half_mask(cur_half) : 2'b00;
      if (wr) begin
        buf_addr_o <= {cur_half, widx[ADDR_W-2:0]};
        buf_dat_o  <= word_done ? word : part;
        widx       <= widx + ADDR_W'(1);
      end
      if (state == ST_MARK) begin
        cur_half <= ~cur_half;
        widx     <= '0;
      end
    end
endmodule

// File: tb/tb_surf6_fwu_buffer_writer.sv
// tb_surf6_fwu_buffer_writer: scoreboard bench for surf6_fwu_buffer_writer with 4-word halves.
module tb_surf6_fwu_buffer_writer;
  localparam int HW = 4;
  localparam int AW = 3;
  logic ifclk_i = 1'b0;
  logic rst_n_i = 1'b0;
  logic [7:0] fwu_dat_i = '0;
  logic fwu_valid_i = 1'b0;
  logic fwu_ready_o;
  logic fwu_mark_i = 1'b0;
  logic [AW-1:0] buf_addr_o;
  logic [31:0] buf_dat_o;
  logic buf_we_o;
  logic [1:0] fw_wr_o, fw_mark_o;
  logic cur_half_o;
  always #5 ifclk_i = ~ifclk_i;
  surf6_fwu_buffer_writer #(.HALF_WORDS(HW)) dut (
    .ifclk_i    (ifclk_i),
    .rst_n_i    (rst_n_i),
    .fwu_dat_i  (fwu_dat_i),
    .fwu_valid_i(fwu_valid_i),
    .fwu_ready_o(fwu_ready_o),
    .fwu_mark_i (fwu_mark_i),
    .buf_addr_o (buf_addr_o),
    .buf_dat_o  (buf_dat_o),
    .buf_we_o   (buf_we_o),
    .fw_wr_o    (fw_wr_o),
    .fw_mark_o  (fw_mark_o),
    .cur_half_o (cur_half_o)
  );
  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   dat;
    logic [1:0]    wr;
  } wr_t;
  wr_t exp_wr[$];
  logic [1:0] exp_mk[$];
  int errors = 0;
  int checks = 0;
  int m_half, m_widx, m_cnt;
  logic [31:0] m_word;
  wr_t mon_e;
  logic [1:0] mon_m;
  task automatic push_write();
    wr_t t;
    t.addr = AW'(m_half * HW + m_widx);
    t.dat  = m_word;
    t.wr   = (m_widx == 0) ? 2'(1 << m_half) : 2'b00;
    exp_wr.push_back(t);
    m_widx++;
    m_cnt  = 0;
    m_word = '0;
  endtask
  task automatic model_byte(input logic [7:0] b);
    m_word[8*m_cnt +: 8] = b;
    m_cnt++;
    if (m_cnt == 4) push_write();
  endtask
  task automatic model_mark();
    if (m_widx != 0 || m_cnt != 0) begin
      if (m_cnt != 0) push_write();
      exp_mk.push_back(2'(1 << m_half));
      m_half ^= 1;
      m_widx = 0;
      m_cnt  = 0;
      m_word = '0;
    end
  endtask
  always @(negedge ifclk_i) begin
    if (buf_we_o === 1'b1) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0h dat=%08h wr=%b, none required", buf_addr_o, buf_dat_o, fw_wr_o);
      end else begin
        mon_e = exp_wr.pop_front();
        if ({buf_addr_o, buf_dat_o, fw_wr_o} !== {mon_e.addr, mon_e.dat, mon_e.wr}) begin
          errors++;
          $display("FAIL write got addr=%0h dat=%08h wr=%b required addr=%0h dat=%08h wr=%b",
                   buf_addr_o, buf_dat_o, fw_wr_o, mon_e.addr, mon_e.dat, mon_e.wr);
        end
      end
    end else if (fw_wr_o !== 2'b00) begin
      checks++;
      errors++;
      $display("FAIL fw_wr_without_write got %b required 00", fw_wr_o);
    end
    if (fw_mark_o !== 2'b00) begin
      checks++;
      if (exp_mk.size() == 0) begin
        errors++;
        $display("FAIL unexpected_mark got %b required 00", fw_mark_o);
      end else begin
        mon_m = exp_mk.pop_front();
        if (fw_mark_o !== mon_m) begin
          errors++;
          $display("FAIL mark got %b required %b", fw_mark_o, mon_m);
        end
      end
    end
  end
  task automatic tick();
    @(posedge ifclk_i);
    #1;
  endtask
  task automatic apply_reset();
    rst_n_i = 1'b0;
    fwu_valid_i = 1'b0;
    fwu_mark_i = 1'b0;
    exp_wr.delete();
    exp_mk.delete();
    m_half = 0;
    m_widx = 0;
    m_cnt  = 0;
    m_word = '0;
    @(negedge ifclk_i);
    checks++;
    if ({fwu_ready_o, buf_we_o, buf_addr_o, buf_dat_o, fw_wr_o, fw_mark_o, cur_half_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b we=%b addr=%0h dat=%08h wr=%b mk=%b half=%b required all 0",
               fwu_ready_o, buf_we_o, buf_addr_o, buf_dat_o, fw_wr_o, fw_mark_o, cur_half_o);
    end
    tick();
    tick();
    rst_n_i = 1'b1;
    @(negedge ifclk_i);
    checks++;
    if (fwu_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge got %b required 0", fwu_ready_o);
    end
    @(negedge ifclk_i);
    checks++;
    if (fwu_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_edge got %b required 1", fwu_ready_o);
    end
    tick();
  endtask
  task automatic send_byte(input logic [7:0] b, input logic mk = 1'b0);
    int n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    fwu_dat_i   = b;
    fwu_valid_i = 1'b1;
    fwu_mark_i  = mk;
    while (!ok && n < 40) begin
      @(negedge ifclk_i);
      ok = fwu_ready_o;
      tick();
      fwu_mark_i = 1'b0;
      n++;
    end
    fwu_valid_i = 1'b0;
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL byte_accept byte=%02h got no ready in %0d cycles required accept", b, n);
    end else begin
      model_byte(b);
      if (mk) model_mark();
    end
  endtask
  task automatic do_mark();
    fwu_mark_i = 1'b1;
    tick();
    fwu_mark_i = 1'b0;
    model_mark();
  endtask
  task automatic drain();
    int n;
    n = 0;
    while ((exp_wr.size() != 0 || exp_mk.size() != 0) && n < 30) begin
      tick();
      n++;
    end
    repeat (3) tick();
    checks++;
    if (exp_wr.size() != 0 || exp_mk.size() != 0) begin
      errors++;
      $display("FAIL drain got pending writes=%0d marks=%0d required 0 0", exp_wr.size(), exp_mk.size());
    end
  endtask
  task automatic check_half(input string name, input logic h);
    checks++;
    if (cur_half_o !== h) begin
      errors++;
      $display("FAIL %s cur_half got %b required %b", name, cur_half_o, h);
    end
  endtask
  task automatic test_reset();
    apply_reset();
  endtask
  task automatic test_two_words();
    apply_reset();
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    do_mark();
    drain();
    check_half("two_words", 1'b1);
  endtask
  task automatic test_flush();
    apply_reset();
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    do_mark();
    drain();
    check_half("flush", 1'b1);
  endtask
  task automatic test_full();
    apply_reset();
    for (int i = 1; i <= 16; i++) send_byte(8'(i));
    fwu_dat_i = 8'd17;
    fwu_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge ifclk_i);
      checks++;
      if (fwu_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL full_stall cycle %0d ready got %b required 0", i, fwu_ready_o);
      end
      tick();
    end
    do_mark();
    for (int i = 17; i <= 20; i++) send_byte(8'(i));
    drain();
    check_half("full", 1'b1);
  endtask
  task automatic test_same_cycle();
    apply_reset();
    for (int i = 1; i <= 3; i++) send_byte(8'(i));
    send_byte(8'd4, 1'b1);
    drain();
    check_half("same_cycle", 1'b1);
    do_mark();
    repeat (4) tick();
    check_half("idle_mark", 1'b1);
    drain();
  endtask
  task automatic test_back_to_back();
    apply_reset();
    for (int h = 0; h < 2; h++) begin
      for (int i = 0; i < 4; i++) send_byte(8'(8'h30 + h * 16 + i));
      do_mark();
      drain();
    end
    check_half("back_to_back", 1'b0);
    for (int i = 0; i < 4; i++) send_byte(8'(8'hC0 + i));
    drain();
  endtask
  task automatic test_reset_mid();
    apply_reset();
    for (int i = 1; i <= 6; i++) send_byte(8'(8'h50 + i));
    drain();
    apply_reset();
    for (int i = 1; i <= 4; i++) send_byte(8'(8'hA0 + i));
    drain();
    check_half("reset_mid", 1'b0);
  endtask
  initial begin
    tick();
    test_reset();
    test_two_words();
    test_flush();
    test_full();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #300000;
    $display("FAIL global_timeout got no finish required finish");
    $fatal(1, "timeout");
  end
endmodule
